// File: rtl/adder_share_arbiter.sv
// One registered adder shared by NREQ requesters through a round-robin arbiter.
// The result register is a one-deep skid: it refills in the same cycle it drains.
module adder_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = $clog2(NREQ),
    parameter int unsigned CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_carry,
    output logic [IDW-1:0]        res_id,
    output logic [CNTW-1:0]       ops_count,
    output logic                  busy
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDW-1:0]   r_id;
    logic [CNTW-1:0]  r_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_idx;
    logic             w_can_accept;
    logic             w_grant;
    logic [NREQ-1:0]  w_onehot;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum_full;
    logic [IDW-1:0]   w_ptr_next;

    // Scan from the pointer, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_can_accept = (r_state == StEmpty) | res_ready;
    assign w_grant      = w_found & w_can_accept & ~rst;
    assign w_onehot     = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign req_ready    = w_grant ? w_onehot : '0;

    assign w_a        = req_a[w_win*WIDTH +: WIDTH];
    assign w_b        = req_b[w_win*WIDTH +: WIDTH];
    assign w_sum_full = {1'b0, w_a} + {1'b0, w_b};
    assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StEmpty: if (w_grant) w_state_d = StFull;
            StFull:  if (!w_grant && res_ready) w_state_d = StEmpty;
            default: w_state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_grant) begin
                r_sum   <= w_sum_full[WIDTH-1:0];
                r_carry <= w_sum_full[WIDTH];
                r_id    <= w_win;
                r_ptr   <= w_ptr_next;
            end
            // Saturating count of delivered results.
            if ((r_state == StFull) && res_ready && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign res_valid = (r_state == StFull);
    assign busy      = (r_state == StFull);
    assign res_sum   = r_sum;
    assign res_carry = r_carry;
    assign res_id    = r_id;
    assign ops_count = r_cnt;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: a reference arbiter model pushes expected
// results into a scoreboard queue at grant time and pops them on delivery.
module tb_adder_share_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CNTW  = 16;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_carry;
    logic [IDW-1:0]        res_id;
    logic [CNTW-1:0]       ops_count;
    logic                  busy;

    adder_share_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_carry(res_carry),
        .res_id   (res_id),
        .ops_count(ops_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int sb[$];       // {id, carry, sum} packed as id<<16 | carry<<8 | sum
    int ids_seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Check one cycle against the model, then advance model and DUT across one edge.
    task automatic step();
        int              win;
        int              idx;
        int              e;
        int              s;
        bit              found;
        bit              full;
        logic [NREQ-1:0] exp_rdy;
        #1;
        full  = (sb.size() != 0);
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        exp_rdy = '0;
        if (!rst && found && (!full || res_ready)) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(full));
        chk("busy", 32'(busy), 32'(full));
        chk("ops_count", 32'(ops_count), 32'(m_cnt));
        if (full) begin
            e = sb[0];
            chk("res_sum", 32'(res_sum), 32'(e & 255));
            chk("res_carry", 32'(res_carry), 32'((e >> 8) & 1));
            chk("res_id", 32'(res_id), 32'(e >> 16));
        end
        if (!rst && res_valid && res_ready) ids_seen.push_back(int'(res_id));
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            if (full && res_ready) begin
                void'(sb.pop_front());
                if (m_cnt < 65535) m_cnt++;
            end
            if (exp_rdy != '0) begin
                s = int'(req_a[win*WIDTH +: WIDTH]) + int'(req_b[win*WIDTH +: WIDTH]);
                sb.push_back((win << 16) | (((s >> 8) & 1) << 8) | (s & 255));
                m_ptr = (win + 1) % NREQ;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        @(negedge clk);

        // Reset held two cycles with every requester valid.
        step();
        step();
        chk("rst_sum", 32'(res_sum), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        rst = 1'b0;
        set_op(0, 8'h05, 8'h07);
        step();
        chk("first_grant_id", 32'(res_id), 32'h0);
        chk("first_grant_sum", 32'(res_sum), 32'h0c);
        req_valid = '0;
        step();

        // Single request from requester 1 after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_op(1, 8'h12, 8'h34);
        req_valid = 4'b0010;
        step();
        chk("single_sum", 32'(res_sum), 32'h46);
        chk("single_carry", 32'(res_carry), 32'h0);
        chk("single_id", 32'(res_id), 32'h1);
        req_valid = '0;
        step();
        chk("single_count", 32'(ops_count), 32'h1);

        // Round-robin with all requesters valid for eight cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ids_seen.delete();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom));
            step();
        end
        req_valid = '0;
        step();
        chk("rr_count", 32'(ops_count), 32'h8);
        chk("rr_len", 32'(ids_seen.size()), 32'h8);
        for (int k = 0; k < 8 && k < ids_seen.size(); k++) begin
            chk("rr_order", 32'(ids_seen[k]), 32'(k % 4));
        end

        // Overflowing operands, then backpressure with everyone requesting.
        set_op(2, 8'hFF, 8'h01);
        req_valid = 4'b0100;
        step();
        req_valid = '1;
        res_ready = 1'b0;
        repeat (5) step();
        chk("bp_sum", 32'(res_sum), 32'h0);
        chk("bp_carry", 32'(res_carry), 32'h1);
        chk("bp_id", 32'(res_id), 32'h2);
        chk("bp_ready", 32'(req_ready), 32'h0);
        res_ready = 1'b1;
        #1 chk("bp_resume", 32'(req_ready), 32'b1000);
        step();

        // Pointer now 0; only requester 2 valid, so 0 and 1 are skipped.
        req_valid = 4'b0100;
        #1 chk("skip_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '1;
        #1 chk("ptr_after_skip", 32'(req_ready), 32'b1000);
        step();

        // Reset while a result is pending; it must never be delivered.
        req_valid = '0;
        res_ready = 1'b0;
        step();
        chk("pend_valid", 32'(res_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(res_valid), 32'h0);
        chk("mid_rst_count", 32'(ops_count), 32'h0);
        res_ready = 1'b1;
        step();
        step();
        req_valid = '1;
        #1 chk("mid_rst_ptr", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        chk("final_count", 32'(ops_count), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
